// File: rtl/noc_response_port_if.sv
// Handshake bundle between the memory FSM, the response serialiser and the NoC transmit lane.
// The slave view is the serialiser; the master view is whatever drives it (memory FSM plus NoC sink).
interface noc_response_port_if;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_opcode;
    logic [1:0] resp_status;
    logic [3:0] resp_len;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] data_byte;
    logic       noc_tx_valid;
    logic       noc_tx_ready;
    logic       noc_tx_bit;
    logic       noc_tx_sof;
    logic       noc_tx_eom;
    logic       resp_done;
    logic       busy;

    modport master (
        output resp_valid, resp_opcode, resp_status, resp_len,
        output data_valid, data_byte, noc_tx_ready,
        input  resp_ready, data_ready, noc_tx_valid, noc_tx_bit,
        input  noc_tx_sof, noc_tx_eom, resp_done, busy
    );

    modport slave (
        input  resp_valid, resp_opcode, resp_status, resp_len,
        input  data_valid, data_byte, noc_tx_ready,
        output resp_ready, data_ready, noc_tx_valid, noc_tx_bit,
        output noc_tx_sof, noc_tx_eom, resp_done, busy
    );
endinterface

// File: rtl/noc_response_port.sv
// Serialises a memory-FSM response (header frame plus optional read-data frames) onto the
// NoC as 16-bit frames, MSB first, one bit per accepted cycle.
module noc_response_port #(
    parameter int FRAME_W = 16,
    parameter int MAX_LEN = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_response_port_if.slave   bus
);
    localparam int         CNT_W     = $clog2(FRAME_W);
    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t               state_reg;
    logic [FRAME_W-1:0]   shreg_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [3:0]           remain_reg;
    logic                 byte_idx_reg;
    logic                 resp_ready_reg;
    logic                 tx_valid_reg;
    logic                 data_ready_reg;
    logic                 resp_done_reg;
    logic                 busy_reg;

    logic [3:0]           eff_len;
    logic                 tx_fire;
    logic                 last_bit;
    logic                 byte_fire;

    // Non-OK responses never carry data, whatever length the FSM reports.
    always_comb begin
        eff_len = 4'd0;
        if (bus.resp_status == 2'b00) begin
            eff_len = (bus.resp_len > MAX_LEN_L) ? MAX_LEN_L : bus.resp_len;
        end
    end

    assign tx_fire   = tx_valid_reg & bus.noc_tx_ready;
    assign last_bit  = (cnt_reg == CNT_W'(FRAME_W - 1));
    assign byte_fire = data_ready_reg & bus.data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            shreg_reg      <= '0;
            cnt_reg        <= '0;
            remain_reg     <= '0;
            byte_idx_reg   <= 1'b0;
            resp_ready_reg <= 1'b1;
            tx_valid_reg   <= 1'b0;
            data_ready_reg <= 1'b0;
            resp_done_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.resp_valid) begin
                        shreg_reg      <= {bus.resp_opcode, bus.resp_status, 2'b00, eff_len};
                        remain_reg     <= eff_len;
                        cnt_reg        <= '0;
                        resp_ready_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                        tx_valid_reg   <= 1'b1;
                        state_reg      <= ST_HDR;
                    end
                end
                // Header and data frames share the bit engine; remain_reg already
                // reflects bytes still to fetch, so zero means this is the final frame.
                ST_HDR, ST_SHIFT: begin
                    if (tx_fire) begin
                        shreg_reg <= shreg_reg << 1;
                        cnt_reg   <= cnt_reg + 1'b1;
                        if (last_bit) begin
                            tx_valid_reg <= 1'b0;
                            if (remain_reg != 4'd0) begin
                                data_ready_reg <= 1'b1;
                                byte_idx_reg   <= 1'b0;
                                state_reg      <= ST_FETCH;
                            end else begin
                                resp_done_reg <= 1'b1;
                                state_reg     <= ST_DONE;
                            end
                        end
                    end
                end
                ST_FETCH: begin
                    if (byte_fire) begin
                        remain_reg <= remain_reg - 1'b1;
                        if (!byte_idx_reg) begin
                            shreg_reg <= {bus.data_byte, {(FRAME_W-8){1'b0}}};
                        end else begin
                            shreg_reg[7:0] <= bus.data_byte;
                        end
                        if (byte_idx_reg || (remain_reg == 4'd1)) begin
                            data_ready_reg <= 1'b0;
                            tx_valid_reg   <= 1'b1;
                            cnt_reg        <= '0;
                            state_reg      <= ST_SHIFT;
                        end else begin
                            byte_idx_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    resp_done_reg  <= 1'b0;
                    busy_reg       <= 1'b0;
                    resp_ready_reg <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    resp_ready_reg <= 1'b1;
                    tx_valid_reg   <= 1'b0;
                    data_ready_reg <= 1'b0;
                    resp_done_reg  <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.resp_ready   = resp_ready_reg;
    assign bus.data_ready   = data_ready_reg;
    assign bus.noc_tx_valid = tx_valid_reg;
    assign bus.noc_tx_bit   = tx_valid_reg & shreg_reg[FRAME_W-1];
    assign bus.noc_tx_sof   = tx_valid_reg & (cnt_reg == '0);
    assign bus.noc_tx_eom   = tx_valid_reg & last_bit & (remain_reg == 4'd0);
    assign bus.resp_done    = resp_done_reg;
    assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_noc_response_port.sv
// Scoreboard bench for noc_response_port: stimulus queues hand-computed frames, a monitor
// reassembles accepted bits into frames and compares them.
module tb_noc_response_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_response_port_if bus ();

    noc_response_port #(.FRAME_W(16), .MAX_LEN(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [15:0] word;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  data_q[$];
    logic        ready_pat[$];
    int          data_hold = 0;

    int n_checks = 0;
    int n_fail   = 0;

    int          bitpos = 0;
    int          frame_cnt = 0;
    int          done_cnt = 0;
    int          byte_hs = 0;
    int          dr_cycles = 0;
    logic [15:0] shw = '0;

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %04h expected %04h", name, act, req);
        end
    endtask

    task automatic checkn(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, inputs only change just after the rising edge.
    initial begin : monitor
        logic prev_stall, prev_bit, prev_sof, prev_eom, exp_last;
        exp_t e;
        prev_stall = 1'b0; prev_bit = 1'b0; prev_sof = 1'b0; prev_eom = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bitpos     = 0;
                prev_stall = 1'b0;
            end else begin
                if (bus.resp_done) done_cnt++;
                if (bus.data_ready) begin
                    dr_cycles++;
                    check1("no_valid_in_fetch", bus.noc_tx_valid, 1'b0);
                end
                if (!bus.noc_tx_valid) check1("bit_zero_when_invalid", bus.noc_tx_bit, 1'b0);
                if (bitpos != 0) check1("valid_held_midframe", bus.noc_tx_valid, 1'b1);
                if (prev_stall && bus.noc_tx_valid) begin
                    check1("stall_hold_bit", bus.noc_tx_bit, prev_bit);
                    check1("stall_hold_sof", bus.noc_tx_sof, prev_sof);
                    check1("stall_hold_eom", bus.noc_tx_eom, prev_eom);
                end
                if (bus.noc_tx_valid && bus.noc_tx_ready) begin
                    exp_last = (exp_q.size() > 0) ? exp_q[0].last : 1'b0;
                    check1("sof", bus.noc_tx_sof, bitpos == 0);
                    check1("eom", bus.noc_tx_eom, (bitpos == 15) && exp_last);
                    shw = {shw[14:0], bus.noc_tx_bit};
                    bitpos++;
                    if (bitpos == 16) begin
                        bitpos = 0;
                        frame_cnt++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_frame: got %04h expected none", shw);
                        end else begin
                            e = exp_q.pop_front();
                            check16("frame", shw, e.word);
                            $display("frame %0d: %04h (expected %04h)", frame_cnt, shw, e.word);
                        end
                    end
                end
                prev_stall = bus.noc_tx_valid & ~bus.noc_tx_ready;
                prev_bit   = bus.noc_tx_bit;
                prev_sof   = bus.noc_tx_sof;
                prev_eom   = bus.noc_tx_eom;
            end
        end
    end

    // Read-data source: offers the head of data_q, optionally withheld for data_hold FETCH cycles.
    initial begin : feeder
        logic fire, dr;
        bus.data_valid = 1'b0;
        bus.data_byte  = 8'h00;
        forever begin
            @(negedge clk);
            fire = bus.data_valid & bus.data_ready & ~rst;
            dr   = bus.data_ready & ~rst;
            @(posedge clk);
            #1;
            if (fire && data_q.size() > 0) begin
                void'(data_q.pop_front());
                byte_hs++;
            end
            if (dr && data_hold > 0) data_hold--;
            bus.data_valid = (data_hold == 0) && (data_q.size() > 0);
            bus.data_byte  = (data_q.size() > 0) ? data_q[0] : 8'h00;
        end
    end

    initial begin : sink
        bus.noc_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.noc_tx_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
        end
    end

    task automatic push_exp(input logic [15:0] w, input logic last);
        exp_t e;
        e.word = w;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] op, input logic [1:0] st, input logic [3:0] len);
        bit accepted;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        bus.resp_opcode = op;
        bus.resp_status = st;
        bus.resp_len    = len;
        bus.resp_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.resp_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check1("resp_accepted", accepted, 1'b1);
        @(posedge clk);
        #1;
        bus.resp_valid = 1'b0;
        $display("issued response op=%02h st=%0d len=%0d", op, st, len);
    endtask

    task automatic wait_done(input int target);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) begin
                seen = 1'b1;
                break;
            end
        end
        check1("resp_done_seen", seen, 1'b1);
        repeat (2) @(posedge clk);
        checkn("exp_queue_drained", exp_q.size(), 0);
        checkn("no_partial_frame", bitpos, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        rst             = 1'b1;
        bus.resp_valid  = 1'b0;
        bus.resp_opcode = 8'h00;
        bus.resp_status = 2'b00;
        bus.resp_len    = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_resp_ready", bus.resp_ready, 1'b1);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_tx_valid", bus.noc_tx_valid, 1'b0);
        check1("rst_data_ready", bus.data_ready, 1'b0);
        check1("rst_resp_done", bus.resp_done, 1'b0);
        check1("rst_sof_eom_bit", bus.noc_tx_sof | bus.noc_tx_eom | bus.noc_tx_bit, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write ack with exact cycle timing: bits on cycles 1..16, done on 17, ready on 18.
        push_exp(16'h0200, 1'b1);
        issue(8'h02, 2'b00, 4'd0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check1("ack_valid", bus.noc_tx_valid, 1'b1);
            check1("ack_sof_timing", bus.noc_tx_sof, k == 1);
            check1("ack_eom_timing", bus.noc_tx_eom, k == 16);
            check1("ack_resp_ready_low", bus.resp_ready, 1'b0);
            check1("ack_busy", bus.busy, 1'b1);
        end
        @(negedge clk);
        check1("ack_done_cycle17", bus.resp_done, 1'b1);
        check1("ack_valid_off_cycle17", bus.noc_tx_valid, 1'b0);
        check1("ack_ready_low_cycle17", bus.resp_ready, 1'b0);
        @(negedge clk);
        check1("ack_ready_cycle18", bus.resp_ready, 1'b1);
        check1("ack_busy_cycle18", bus.busy, 1'b0);
        check1("ack_done_pulse_1cyc", bus.resp_done, 1'b0);
        repeat (2) @(posedge clk);

        // Read of three bytes: odd count pads the last frame.
        base = byte_hs;
        data_q = '{8'hA5, 8'h3C, 8'hF0};
        push_exp(16'h0303, 1'b0);
        push_exp(16'hA53C, 1'b0);
        push_exp(16'hF000, 1'b1);
        issue(8'h03, 2'b00, 4'd3);
        wait_done(2);
        checkn("read_byte_handshakes", byte_hs - base, 3);

        // Error status forces the length field to zero and skips FETCH entirely.
        base = dr_cycles;
        push_exp(16'hD840, 1'b1);
        issue(8'hD8, 2'b01, 4'd5);
        wait_done(3);
        checkn("err_no_data_ready", dr_cycles - base, 0);

        // Backpressure through an ack.
        for (int i = 0; i < 24; i++) begin
            ready_pat.push_back(1'b1);
            ready_pat.push_back(1'b0);
            ready_pat.push_back(1'b0);
            ready_pat.push_back(1'b1);
        end
        base = frame_cnt;
        push_exp(16'h9900, 1'b1);
        issue(8'h99, 2'b00, 4'd0);
        wait_done(4);
        checkn("bp_one_frame", frame_cnt - base, 1);

        // Data withheld for 20 FETCH cycles.
        data_hold = 20;
        data_q = '{8'h11, 8'h22};
        push_exp(16'h0302, 1'b0);
        push_exp(16'h1122, 1'b1);
        issue(8'h03, 2'b00, 4'd2);
        wait_done(5);
        checkn("stall_hold_expired", data_hold, 0);

        // Reset in the middle of a data frame abandons the response.
        data_q = '{8'h5A, 8'hC3};
        push_exp(16'h0302, 1'b0);
        base = frame_cnt;
        issue(8'h03, 2'b00, 4'd2);
        begin
            bit reached;
            reached = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                #1;
                if (frame_cnt == base + 1 && bitpos == 8) begin
                    reached = 1'b1;
                    break;
                end
            end
            check1("reached_midframe", reached, 1'b1);
        end
        base = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("midrst_tx_valid", bus.noc_tx_valid, 1'b0);
        check1("midrst_resp_ready", bus.resp_ready, 1'b1);
        check1("midrst_busy", bus.busy, 1'b0);
        check1("midrst_done", bus.resp_done, 1'b0);
        check1("midrst_data_ready", bus.data_ready, 1'b0);
        check1("midrst_sof_eom_bit", bus.noc_tx_sof | bus.noc_tx_eom | bus.noc_tx_bit, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_q.delete();
        repeat (30) @(posedge clk);
        checkn("midrst_no_done", done_cnt - base, 0);
        checkn("midrst_queue_empty", exp_q.size(), 0);

        // A fresh response after the abort starts cleanly from its header.
        push_exp(16'h5200, 1'b1);
        issue(8'h52, 2'b00, 4'd0);
        wait_done(base + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
